// File: rtl/gf180mcu_nand_tree_pipe.sv
// Pipelined, parametrised NAND/AND reduction tree over CHANNELS independent lanes.
// Each level ANDs groups of 4 (padded with 1) and registers the result; MODE rides along.
module gf180mcu_nand_tree_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                        CLK,
  input  logic                        RN,
  input  logic [CHANNELS*WIDTH-1:0]   A,
  input  logic                        MODE,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [CHANNELS-1:0]         ZN,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY
);

  // Number of signals entering level lvl+1 (lvl = 0 is the raw input).
  function automatic int width_at(input int lvl);
    int n;
    n = WIDTH;
    for (int i = 0; i < 8; i++) begin
      if (i < lvl) n = (n + 3) / 4;
    end
    return n;
  endfunction

  function automatic int calc_levels();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if (n > 1) begin
        n = (n + 3) / 4;
        l++;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  // Bit offset of level lvl (1-based) inside the flat per-channel register vector.
  function automatic int reg_off(input int lvl);
    int o;
    o = 0;
    for (int i = 1; i < 9; i++) begin
      if (i < lvl) o += width_at(i);
    end
    return o;
  endfunction

  localparam int LEVELS   = calc_levels();
  localparam int REG_BITS = reg_off(LEVELS + 1);

  if (WIDTH < 2 || WIDTH > 256 || CHANNELS < 1) begin : g_bad_params
    $error("gf180mcu_nand_tree_pipe: WIDTH must be 2..256 and CHANNELS >= 1");
  end

  logic [LEVELS-1:0]                        valid_q;
  logic [LEVELS-1:0]                        mode_q;
  logic [CHANNELS-1:0][REG_BITS-1:0]        tree_q;
  logic [CHANNELS-1:0][REG_BITS-1:0]        tree_d;
  logic                                     advance;

  assign advance   = ~(OUT_VALID & ~OUT_READY);
  assign IN_READY  = advance;
  assign OUT_VALID = valid_q[LEVELS-1];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IW = width_at(k - 1);
    localparam int OW = width_at(k);
    localparam int IO = reg_off(k - 1);
    localparam int OO = reg_off(k);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [IW-1:0] src;

      if (k == 1) begin : g_from_port
        assign src = A[c*WIDTH +: WIDTH];
      end else begin : g_from_reg
        assign src = tree_q[c][IO +: IW];
      end

      for (genvar g = 0; g < OW; g++) begin : g_grp
        logic [3:0] grp;
        for (genvar j = 0; j < 4; j++) begin : g_bit
          // Missing inputs of the last group read as 1 so they never pull the AND low.
          if (4*g + j < IW) begin : g_real
            assign grp[j] = src[4*g + j];
          end else begin : g_pad
            assign grp[j] = 1'b1;
          end
        end
        assign tree_d[c][OO + g] = &grp;
      end
    end
  end

  // NOTE: data registers are reset too so ZN and every stage read a defined 0 after RN,
  // even though only the valid bits are functionally required.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      valid_q <= '0;
      mode_q  <= '0;
      tree_q  <= '0;
    end else if (advance) begin
      valid_q <= (valid_q << 1) | LEVELS'(IN_VALID);
      mode_q  <= (mode_q << 1) | LEVELS'(MODE);
      tree_q  <= tree_d;
    end
  end

  // Output is forced low whenever no valid beat is presented.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    logic and_c;
    assign and_c = tree_q[c][REG_BITS-1];
    assign ZN[c] = OUT_VALID & (mode_q[LEVELS-1] ? and_c : ~and_c);
  end

endmodule
